interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
- Prioritised interrupt controller directly upstream of the hazard control unit; drives its interrupt request and 14-bit vector address.
- Synchronises external IRQ lines, latches pending events, applies per-line and global masks, and selects the highest-priority request.
- Holds the request until the hazard unit reports it taken, then blocks further requests (no nesting) until return-from-interrupt.

Parameters:
NUM_IRQ, 8, number of IRQ lines; legal 1..8; id width fixed at 3 bits.
VECTOR_BASE, 14'h0010, vector address of IRQ 0.
VECTOR_STRIDE, 4, address spacing between consecutive vectors.

Ports:
clock  input  1  system clock; all state updates on rising edge.
nreset  input  1  asynchronous active-low reset.
irq_lines  input  NUM_IRQ  external interrupt sources, asynchronous to clock.
control_state  input  3  hazard unit state; 3'h2 = interrupt state, i.e. request taken.
reti  input  1  one-cycle pulse: return-from-interrupt retired.
cfg_we  input  1  configuration write strobe.
cfg_addr  input  2  register select: 0 mask, 1 pending W1C, 2 global enable (bit0), 3 software set-pending.
cfg_wdata  input  NUM_IRQ  configuration write data.
cfg_rdata  output  NUM_IRQ  combinational read: 0 mask, 1 pending, 2 {in_service_id[2:0], state[1:0]} zero-extended/truncated, 3 zero.
interrupt  output  1  request to hazard unit.
interrupt_vector_address  output  14  vector of selected/in-service IRQ.
in_service  output  1  high while handler active.

Behaviour:
- Reset (async, nreset low): sync flops, pending, mask, global_en, state, selected id, interrupt, interrupt_vector_address, in_service all 0; state IDLE. Reset mid-request or mid-service drops everything; no vector retained.
- Input path: two-flop synchroniser per line, then a third flop for rising-edge detect. Edge-to-pending latency = 3 rising edges.
- Pending bit i: set on edge i or cfg write addr 3 with wdata[i]=1. Cleared on cfg write addr 1 with wdata[i]=1, or when IRQ i is taken.
- Set beats clear in the same cycle; a new edge coincident with take leaves the bit pending.
- eligible = pending & mask, qualified by global_en. Priority: lowest index wins.
- FSM:
  - IDLE: if eligible != 0 then latch id = lowest set bit, go REQUEST.
  - REQUEST: interrupt=1. vector = VECTOR_BASE + id*VECTOR_STRIDE, truncated to 14 bits, registered on entry and held constant in REQUEST.
    - If control_state==3'h2 is sampled: clear pending[id], interrupt=0 next cycle, go IN_SERVICE.
    - Else if pending[id]&mask[id]&global_en drops: withdraw, interrupt=0, go IDLE.
    - The latched id is never re-arbitrated while in REQUEST, even if a higher priority arrives.
  - IN_SERVICE: in_service=1, interrupt=0. Vector holds its value through the whole service (hazard unit reads it combinationally during its interrupt state). Pending events keep accumulating.
    - On reti: go IDLE; re-arbitration starts next cycle.
- reti outside IN_SERVICE: ignored. control_state==3'h2 outside REQUEST: ignored.
- Clock-phase rule: the hazard unit updates control_state on the falling edge, so it is stable at this block's rising edge. interrupt falls at the first rising edge inside hazard state 2; the hazard unit leaves state 2 unconditionally.
- Minimum request-to-request spacing: REQUEST→IN_SERVICE→(reti)→IDLE→REQUEST = reti + 1 cycle.

Optional Feature:
- Macro: IRQ_LEVEL_EN.
- Defined:
  - Lines are level-sensitive; edge detector removed.
  - pending[i] = synchronised line i, or software-set bit; software bits are cleared by W1C.
  - Take does not clear hardware level; the device must deassert before reti, else the request re-asserts 1 cycle after IDLE.
  - Latency = 2 edges.
- Undefined: edge-triggered behaviour as above.

Test Plan:
- Reset, mask=8'hFF, global_en=1, pulse irq_lines[3] → interrupt high 4 edges later (3 to pending, +1 FSM), vector=14'h001C; drive control_state=3'h2 → interrupt low next cycle, in_service=1, pending[3]=0.
- irq 5 and irq 1 edges same cycle → vector 14'h0014 (id 1) first; after reti, vector 14'h0024 (id 5).
- In REQUEST for id 2, write mask=0 → interrupt drops next cycle, state IDLE, pending[2] still 1; restore mask → re-request, vector 14'h0018.
- In IN_SERVICE, pulse irq 0 → no interrupt until reti; reti → interrupt 2 cycles later, vector 14'h0010.
- Write addr 3 wdata 8'h80 → software IRQ 7, vector 14'h002C; W1C addr 1 wdata 8'h80 same cycle as new edge on line 7 → pending stays 1.
- Assert nreset low in REQUEST → interrupt, vector, in_service, mask, pending all 0 immediately (asynchronous).

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Hazard-unit handshake and configuration bus for interrupt_controller.
// The master side is the hazard unit plus the configuration host.
// The slave side is the interrupt controller.
interface interrupt_controller_if #(
  parameter int NUM_IRQ = 8
);
  logic [2:0]         control_state;
  logic               reti;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [NUM_IRQ-1:0] cfg_wdata;
  logic [NUM_IRQ-1:0] cfg_rdata;
  logic               interrupt;
  logic [13:0]        interrupt_vector_address;
  logic               in_service;

  modport master (
    output control_state, reti, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rdata, interrupt, interrupt_vector_address, in_service
  );

  modport slave (
    input  control_state, reti, cfg_we, cfg_addr, cfg_wdata,
    output cfg_rdata, interrupt, interrupt_vector_address, in_service
  );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised, non-nesting interrupt controller feeding the hazard unit.
// External lines are synchronised and latched into pending bits.
// Pending bits are then masked, and the lowest eligible index is requested.
// The request is held until the hazard unit takes it.
// No further request is raised until return-from-interrupt.
// Optional macro IRQ_LEVEL_EN: lines become level-sensitive (no edge detector).
module interrupt_controller #(
  parameter int          NUM_IRQ       = 8,
  parameter logic [13:0] VECTOR_BASE   = 14'h0010,
  parameter int          VECTOR_STRIDE = 4
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [NUM_IRQ-1:0]    irq_lines,
  interrupt_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUEST    = 2'd1,
    IN_SERVICE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [2:0]         sel_id, sel_id_next;
  logic [13:0]        vector, vector_next;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] sw_set;
  logic [NUM_IRQ-1:0] clr_bits;
  logic [NUM_IRQ-1:0] sync1, sync2;
  logic               global_en;
  logic               wr_mask, wr_clear, wr_gen, wr_set;
  logic               take, keep_req, any_eligible;
  logic [2:0]         winner;
  logic [7:0]         pending8, mask8;

  assign wr_mask  = bus.cfg_we && (bus.cfg_addr == 2'd0);
  assign wr_clear = bus.cfg_we && (bus.cfg_addr == 2'd1);
  assign wr_gen   = bus.cfg_we && (bus.cfg_addr == 2'd2);
  assign wr_set   = bus.cfg_we && (bus.cfg_addr == 2'd3);

  // A take is only meaningful while a request is outstanding.
  assign take     = (state == REQUEST) && (bus.control_state == 3'h2);

  assign pending8 = 8'(pending);
  assign mask8    = 8'(mask);
  assign keep_req = pending8[sel_id] & mask8[sel_id] & global_en;

  assign sw_set   = wr_set ? bus.cfg_wdata : '0;
  assign clr_bits = (wr_clear ? bus.cfg_wdata : '0)
                  | (take ? NUM_IRQ'(8'h01 << sel_id) : '0);

  assign eligible     = global_en ? (pending & mask) : '0;
  assign any_eligible = |eligible;

`ifdef IRQ_LEVEL_EN
  logic [NUM_IRQ-1:0] sw_pending;

  // Two-flop synchroniser; the synchronised level is itself the hardware request.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_lines;
      sync2 <= sync1;
    end
  end

  // Software-set bits; a set in the same cycle as a clear wins.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) sw_pending <= '0;
    else         sw_pending <= (sw_pending & ~clr_bits) | sw_set;
  end

  assign pending = sync2 | sw_pending;
`else
  logic [NUM_IRQ-1:0] sync3;
  logic [NUM_IRQ-1:0] edges;

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= irq_lines;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edges = sync2 & ~sync3;

  // Pending latch; a new edge or software set beats a W1C or take clear in the same cycle.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) pending <= '0;
    else         pending <= (pending & ~clr_bits) | edges | sw_set;
  end
`endif

  // Mask and global-enable configuration registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      mask      <= '0;
      global_en <= 1'b0;
    end else begin
      if (wr_mask) mask      <= bus.cfg_wdata;
      if (wr_gen)  global_en <= bus.cfg_wdata[0];
    end
  end

  // Fixed priority: lowest eligible index wins, so scan from the top down.
  always_comb begin
    winner = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // FSM state, latched id and vector registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      sel_id <= 3'd0;
      vector <= 14'd0;
    end else begin
      state  <= state_next;
      sel_id <= sel_id_next;
      vector <= vector_next;
    end
  end

  // Next-state logic; id and vector are captured only on entry to REQUEST.
  always_comb begin
    state_next  = state;
    sel_id_next = sel_id;
    vector_next = vector;
    case (state)
      IDLE: begin
        if (any_eligible) begin
          sel_id_next = winner;
          vector_next = VECTOR_BASE + 14'(winner) * 14'(VECTOR_STRIDE);
          state_next  = REQUEST;
        end
      end
      REQUEST: begin
        if (take)           state_next = IN_SERVICE;
        else if (!keep_req) state_next = IDLE;
      end
      IN_SERVICE: begin
        if (bus.reti) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Combinational register read-back.
  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata = mask;
      2'd1:    bus.cfg_rdata = pending;
      2'd2:    bus.cfg_rdata = NUM_IRQ'({sel_id, state});
      default: bus.cfg_rdata = '0;
    endcase
  end

  assign bus.interrupt                = (state == REQUEST);
  assign bus.in_service               = (state == IN_SERVICE);
  assign bus.interrupt_vector_address = vector;

endmodule
